// File: rtl/clk_pulse_sched.sv
// clk_pulse_sched
//   Multi-channel programmable clock/pulse scheduler. Each channel turns a
//   (period, high time, start phase) triple, all in clk cycles, into a
//   registered square wave / enable stream. One start pulse launches every
//   configured idle channel on the same edge, so relative phases are exact.
//
// Parameters
//   NCH   number of output channels (1..8)
//   CNT_W width of period/ton/phase fields and channel counters
//
// Ports
//   clk, rst_n        system clock (posedge), asynchronous active-low reset
//   cfg_valid/ready   config write handshake; cfg_ready = !pending[cfg_ch]
//   cfg_ch            target channel (out-of-range: accepted and dropped)
//   cfg_period/ton/phase  P, H, Ph for the addressed channel's shadow
//   start, stop       1-cycle launch / force-idle pulses (stop wins)
//   busy              any channel not idle
//   clk_out           generated waveforms, one bit per channel
//   wrap_tick         1-cycle pulse on the last cycle of each period
//
// Build option
//   CLKSCHED_BOUNDARY_UPDATE_EN: a running channel adopts a new config only
//   at its period boundary (glitch-free, no phase re-run). Without it, a
//   running channel adopts the new config on the edge after acceptance and
//   restarts from its phase delay.

module clk_pulse_sched #(
    parameter  int unsigned NCH   = 2,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_ton,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   wrap_tick
);

    typedef enum logic [1:0] {S_IDLE, S_PHASE, S_HIGH, S_LOW} state_t;

    typedef struct packed {
        state_t           st;
        logic [CNT_W-1:0] cnt;
    } ld_t;

    // Entry into a (possibly phase-delayed) waveform. A zero high time
    // starts directly in LOW so the period length is still honoured.
    function automatic ld_t f_enter(input logic [CNT_W-1:0] ph,
                                    input logic [CNT_W-1:0] hh,
                                    input logic [CNT_W-1:0] ll);
        ld_t v_ld;
        if (ph != '0) begin
            v_ld.st  = S_PHASE;
            v_ld.cnt = ph;
        end else if (hh != '0) begin
            v_ld.st  = S_HIGH;
            v_ld.cnt = hh;
        end else begin
            v_ld.st  = S_LOW;
            v_ld.cnt = ll;
        end
        return v_ld;
    endfunction

    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_busy;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_p, r_h, r_ph;
        logic [CNT_W-1:0] r_sp, r_sh, r_sph;
        logic             r_pend, r_clk, r_wrap;
        ld_t              w_nxt;
        logic             w_acc, w_load, w_clk_nxt, w_wrap_nxt, w_wrap_now;
        logic [CNT_W-1:0] w_hh, w_ll;
        logic [CNT_W-1:0] w_src_p, w_src_h, w_src_ph, w_src_hh, w_src_ll;

        assign w_acc = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        // High time is clamped to the period; low time is then never negative.
        assign w_hh = (r_h >= r_p) ? r_p : r_h;
        assign w_ll = r_p - w_hh;

        // Values a launch/reload will run with: a pending shadow is copied on
        // the same edge, so the new waveform must already use it.
        assign w_src_p  = r_pend ? r_sp  : r_p;
        assign w_src_h  = r_pend ? r_sh  : r_h;
        assign w_src_ph = r_pend ? r_sph : r_ph;
        assign w_src_hh = (w_src_h >= w_src_p) ? w_src_p : w_src_h;
        assign w_src_ll = w_src_p - w_src_hh;

        // Last cycle of a period: end of LOW, or end of HIGH when there is no LOW.
        assign w_wrap_now = (r_cnt == CNT_W'(1)) &&
                            ((r_state == S_LOW) || ((r_state == S_HIGH) && (w_ll == '0)));

        always_comb begin
            w_nxt.st   = r_state;
            w_nxt.cnt  = r_cnt;
            w_load     = 1'b0;
            w_clk_nxt  = (r_state == S_HIGH);
            w_wrap_nxt = w_wrap_now;
            if (r_state == S_IDLE) begin
                w_load = r_pend;
                if (start && !stop && (w_src_p != '0))
                    w_nxt = f_enter(w_src_ph, w_src_hh, w_src_ll);
            end else if (stop) begin
                w_nxt      = '{st: S_IDLE, cnt: '0};
                w_clk_nxt  = 1'b0;
                w_wrap_nxt = 1'b0;
            end else begin
                case (r_state)
                    S_PHASE: begin
                        if (r_cnt == CNT_W'(1)) w_nxt = f_enter('0, w_hh, w_ll);
                        else                    w_nxt.cnt = r_cnt - CNT_W'(1);
                    end
                    S_HIGH: begin
                        if (r_cnt != CNT_W'(1))  w_nxt.cnt = r_cnt - CNT_W'(1);
                        else if (w_ll != '0)     w_nxt = '{st: S_LOW,  cnt: w_ll};
                        else                     w_nxt = '{st: S_HIGH, cnt: w_hh};
                    end
                    S_LOW: begin
                        if (r_cnt != CNT_W'(1))  w_nxt.cnt = r_cnt - CNT_W'(1);
                        else if (w_hh != '0)     w_nxt = '{st: S_HIGH, cnt: w_hh};
                        else                     w_nxt = '{st: S_LOW,  cnt: w_ll};
                    end
                    default: ;
                endcase
`ifdef CLKSCHED_BOUNDARY_UPDATE_EN
                if (r_pend && w_wrap_now) begin
                    w_load = 1'b1;
                    if (w_src_p == '0) w_nxt = '{st: S_IDLE, cnt: '0};
                    else               w_nxt = f_enter('0, w_src_hh, w_src_ll);
                end
`else
                if (r_pend) begin
                    w_load     = 1'b1;
                    w_clk_nxt  = 1'b0;
                    w_wrap_nxt = 1'b0;
                    if (w_src_p == '0) w_nxt = '{st: S_IDLE, cnt: '0};
                    else               w_nxt = f_enter(w_src_ph, w_src_hh, w_src_ll);
                end
`endif
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_clk   <= 1'b0;
                r_wrap  <= 1'b0;
                r_pend  <= 1'b0;
                r_p     <= '0;
                r_h     <= '0;
                r_ph    <= '0;
                r_sp    <= '0;
                r_sh    <= '0;
                r_sph   <= '0;
            end else begin
                r_state <= w_nxt.st;
                r_cnt   <= w_nxt.cnt;
                r_clk   <= w_clk_nxt;
                r_wrap  <= w_wrap_nxt;
                if (w_acc) begin
                    r_sp   <= cfg_period;
                    r_sh   <= cfg_ton;
                    r_sph  <= cfg_phase;
                    r_pend <= 1'b1;
                end else if (w_load) begin
                    r_p    <= r_sp;
                    r_h    <= r_sh;
                    r_ph   <= r_sph;
                    r_pend <= 1'b0;
                end
            end
        end

        assign clk_out[g]   = r_clk;
        assign wrap_tick[g] = r_wrap;
        assign w_pend[g]    = r_pend;
        assign w_busy[g]    = (r_state != S_IDLE);
    end

    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NCH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = !w_pend[i];
    end

    assign busy = |w_busy;

endmodule
